uart_packet_forwarder: RTL and testbench
========================================

// Module: uart_packet_forwarder
// PURPOSE
//  Generalised host-side forwarding engine. Accepts one encoded packet of PKT_BYTES bytes.
//  Serialises it byte-by-byte into a uart_tx instance, with selectable byte order.
//  Optionally waits for a response from a uart_command_accumulator, with timeout and automatic resend.
//  Sits between the command decoder/encoder stage and the BLE-side uart_tx/accumulator pair.
// PARAMETERS
//  PKT_BYTES    18       bytes per packet (>=1); pkt_data width = PKT_BYTES*8
//  MSB_FIRST    0        0: byte 0 = pkt_data[7:0] sent first; 1: pkt_data[PKT_BYTES*8-1 -: 8] first
//  TIMEOUT      4000000  clk cycles allowed in RSP_WAIT per attempt
//  MAX_RETRIES  2        resends after a timeout before an error is flagged (0 = no resend)
//  SYNC_STAGES  2        synchroniser depth for tx_done (baud_clk domain), >=2
// PORTS
//  clk           in   1            system clock
//  reset_n       in   1            asynchronous, active-low reset
//  pkt_data      in   PKT_BYTES*8  packet to send; captured when pkt_valid && pkt_ready
//  pkt_valid     in   1            packet offered
//  expect_rsp    in   1            captured with pkt_data; 1 = wait for response after send
//  pkt_ready     out  1            high only in IDLE
//  tx_data       out  8            byte to uart_tx .data
//  tx_load       out  1            to uart_tx .load_data
//  tx_start      out  1            to uart_tx .start_transmit
//  tx_done       in   1            uart_tx .tx_finish (high = transmitter idle), asynchronous to clk
//  rsp_done      in   1            accumulator done pulse
//  rsp_error     in   1            accumulator error pulse
//  soft_reset    out  1            1-cycle pulse to rx/accumulator at end of every transaction
//  busy          out  1            high in any state other than IDLE
//  done          out  1            1-cycle pulse: transaction succeeded
//  error         out  1            1-cycle pulse: transaction failed
//  err_code      out  2            0 none, 1 rsp_error, 2 response timeout; held until next capture
//  attempt       out  $clog2(MAX_RETRIES+2)  attempt number of the current or last transaction, 1-based
// BEHAVIOUR
//  Reset (reset_n low, async) values:
//   - state=IDLE; pkt_ready=1; all other outputs 0.
//   - Packet register, byte index, timeout counter and retry counter are cleared.
//  tx_done passes through a SYNC_STAGES flop chain before use. Only tx_done_s is used; the raw signal is never sampled.
//  States:
//   IDLE:      on pkt_valid, capture pkt_data and expect_rsp. Set idx=0, attempt=1, err_code=0. Go to LOAD.
//   LOAD:      wait for tx_done_s=1. Then drive tx_data=byte(idx) and tx_load=1 for 1 cycle. Go to START.
//   START:     tx_start=1, held until tx_done_s=0 (transmitter accepted). Then go to WAIT_IDLE.
//   WAIT_IDLE: tx_start=0. Wait for tx_done_s=1.
//              If idx==PKT_BYTES-1, go to RSP_WAIT when expect_rsp=1, else to FINISH_OK.
//              Otherwise idx+=1 and go to LOAD.
//   RSP_WAIT:  the counter increments every cycle. Checks in priority order:
//              - rsp_error: err_code=1, go to FINISH_ERR.
//              - rsp_done: go to FINISH_OK.
//              - counter==TIMEOUT-1: timeout (see CONFIGURATION).
//   FINISH_OK:  done=1, soft_reset=1 for one cycle, then IDLE.
//   FINISH_ERR: error=1, soft_reset=1 for one cycle, then IDLE.
//  byte(i) = pkt_data_q[8*i +: 8] when MSB_FIRST=0; pkt_data_q[8*(PKT_BYTES-1-i) +: 8] when MSB_FIRST=1.
//  Minimum gap between the pkt_valid accept and the first tx_load is 1 cycle, plus synchroniser latency.
//  pkt_valid outside IDLE is ignored; the producer must hold it until pkt_ready.
//  rsp_done/rsp_error pulses outside RSP_WAIT are ignored.
//  If rsp_done and rsp_error arrive in the same cycle, error wins.
//  On a resend, the packet register is unchanged and idx returns to 0.
//  Counter width is $clog2(TIMEOUT+1), with no wrap. The counter is cleared on every entry to RSP_WAIT.
//  reset_n low mid-transfer aborts immediately. tx_start/tx_load drop asynchronously, and there is no done/error pulse.
//  The byte in flight inside uart_tx completes on its own.
// CONFIGURATION
//  UART_PKT_FWD_TIMEOUT_EN defined:
//   - Timeout in RSP_WAIT with attempt<=MAX_RETRIES: attempt+=1, soft_reset pulses for 1 cycle, idx=0, go to LOAD.
//   - Timeout with attempt>MAX_RETRIES: err_code=2, go to FINISH_ERR.
//  Undefined:
//   - The counter and retry logic are removed.
//   - RSP_WAIT exits only on rsp_done/rsp_error; err_code=2 is never produced; attempt is constant 1.
// TESTING
//  - Ordering, MSB_FIRST=0, PKT_BYTES=3, pkt_data=24'hA1B2C3, expect_rsp=0 -> tx_data sequence C3,B2,A1; one done pulse; one soft_reset pulse; busy returns to 0.
//  - Ordering, MSB_FIRST=1, same packet -> sequence A1,B2,C3; no tx_load while tx_done_s=0; tx_start held until tx_done_s falls.
//  - Response, expect_rsp=1, rsp_done 50 cycles after the last byte -> done pulse, err_code=0, attempt=1.
//  - Same-cycle events, rsp_done and rsp_error in one cycle during RSP_WAIT -> error pulse, err_code=1, no done.
//  - Timeout, macro on, TIMEOUT=100, MAX_RETRIES=2, no response -> 3 full packet sends; error after the 3rd timeout; err_code=2; attempt=3.
//  - Mid-transfer reset, reset_n low after byte 1 of 3, then pkt_valid re-asserted -> outputs at reset values; next packet starts at byte 0; pkt_valid held while busy is not captured twice.

Source files
------------

// File: rtl/uart_packet_forwarder.sv
// rtl/uart_packet_forwarder.sv - serialises one packet into uart_tx and optionally awaits a response
// Optional response timeout/resend is compiled in when UART_PKT_FWD_TIMEOUT_EN is defined.
module uart_packet_forwarder #(
    parameter int PKT_BYTES   = 18,
    parameter int MSB_FIRST   = 0,
    parameter int TIMEOUT     = 4000000,
    parameter int MAX_RETRIES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [PKT_BYTES*8-1:0]           pkt_data,
    input  logic                             pkt_valid,
    input  logic                             expect_rsp,
    output logic                             pkt_ready,
    output logic [7:0]                       tx_data,
    output logic                             tx_load,
    output logic                             tx_start,
    input  logic                             tx_done,
    input  logic                             rsp_done,
    input  logic                             rsp_error,
    output logic                             soft_reset,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic [$clog2(MAX_RETRIES+2)-1:0] attempt
);
    localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int ATT_W = $clog2(MAX_RETRIES + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_IDLE, S_RSP_WAIT, S_FINISH_OK, S_FINISH_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic [PKT_BYTES*8-1:0]   pkt_q, pkt_d;
    logic                     exp_q, exp_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [ATT_W-1:0]         att_q, att_d;
    logic [1:0]               err_q, err_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     tx_done_s;
    logic                     timeout_hit;
    logic                     retry_ok;
    logic [IDX_W-1:0]         byte_sel;

    assign tx_done_s = sync_q[SYNC_STAGES-1];
    assign byte_sel  = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
    assign tx_data   = pkt_q[8*byte_sel +: 8];
    assign err_code  = err_q;
    assign attempt   = att_q;

`ifdef UART_PKT_FWD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (state_q == S_RSP_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign retry_ok    = (att_q <= ATT_W'(MAX_RETRIES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
    assign retry_ok    = 1'b0;
`endif

    // tx_done lives in the baud clock domain; only the synchronised copy is used
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], tx_done};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pkt_q   <= '0;
            exp_q   <= 1'b0;
            idx_q   <= '0;
            att_q   <= '0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            exp_q   <= exp_d;
            idx_q   <= idx_d;
            att_q   <= att_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        att_d   = att_q;
        err_d   = err_q;
`ifdef UART_PKT_FWD_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: if (pkt_valid) begin
                pkt_d   = pkt_data;
                exp_d   = expect_rsp;
                idx_d   = '0;
                att_d   = ATT_W'(1);
                err_d   = 2'd0;
                state_d = S_LOAD;
            end
            S_LOAD:  if (tx_done_s)  state_d = S_START;
            S_START: if (!tx_done_s) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (tx_done_s) begin
                if (idx_q == LAST_IDX) begin
                    state_d = exp_q ? S_RSP_WAIT : S_FINISH_OK;
`ifdef UART_PKT_FWD_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_RSP_WAIT: begin
`ifdef UART_PKT_FWD_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (rsp_error) begin
                    err_d   = 2'd1;
                    state_d = S_FINISH_ERR;
                end else if (rsp_done) begin
                    state_d = S_FINISH_OK;
                end else if (timeout_hit) begin
                    if (retry_ok) begin
                        att_d   = att_q + 1'b1;
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d   = 2'd2;
                        state_d = S_FINISH_ERR;
                    end
                end
            end
            S_FINISH_OK, S_FINISH_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pkt_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        tx_load    = (state_q == S_LOAD) && tx_done_s;
        tx_start   = (state_q == S_START);
        done       = (state_q == S_FINISH_OK);
        error      = (state_q == S_FINISH_ERR);
        // a resend also clears the receive side before the packet goes out again
        soft_reset = done || error ||
                     (timeout_hit && retry_ok && !rsp_error && !rsp_done);
    end
endmodule

// File: tb/tb_uart_packet_forwarder.sv
// tb/tb_uart_packet_forwarder.sv - directed bench for uart_packet_forwarder (LSB-first and MSB-first instances)
module tb_uart_packet_forwarder;
    localparam int BYTE_CYC = 8;
    localparam int LIMIT    = 2000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] pkt_data = '0;
    logic        expect_rsp = 1'b0;
    logic        rsp_done = 1'b0;
    logic        rsp_error = 1'b0;
    logic [1:0]  pv = 2'b00;
    logic [1:0]  td = 2'b11;

    logic [1:0]  pkt_ready_w, tx_load_w, tx_start_w, soft_w, busy_w, done_w, error_w;
    logic [15:0] tx_data_v;
    logic [3:0]  err_code_v, attempt_v;

    int          nbytes [2];
    logic [7:0]  bytes_q [2][128];
    int          ndone [2], nerr [2], nsoft [2], badload [2], startlow [2], bcnt [2];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          d;
        logic [23:0] pkt;
        logic        er;
        int          mode;
        logic [7:0]  b0, b1, b2;
        int          xdone, xerr;
        logic [1:0]  xcode;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    uart_packet_forwarder #(.PKT_BYTES(3), .MSB_FIRST(0), .TIMEOUT(100), .MAX_RETRIES(2), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .pkt_data(pkt_data), .pkt_valid(pv[0]), .expect_rsp(expect_rsp),
        .pkt_ready(pkt_ready_w[0]), .tx_data(tx_data_v[7:0]), .tx_load(tx_load_w[0]), .tx_start(tx_start_w[0]),
        .tx_done(td[0]), .rsp_done(rsp_done), .rsp_error(rsp_error), .soft_reset(soft_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .error(error_w[0]), .err_code(err_code_v[1:0]), .attempt(attempt_v[1:0]));

    uart_packet_forwarder #(.PKT_BYTES(3), .MSB_FIRST(1), .TIMEOUT(100), .MAX_RETRIES(2), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pkt_data(pkt_data), .pkt_valid(pv[1]), .expect_rsp(expect_rsp),
        .pkt_ready(pkt_ready_w[1]), .tx_data(tx_data_v[15:8]), .tx_load(tx_load_w[1]), .tx_start(tx_start_w[1]),
        .tx_done(td[1]), .rsp_done(rsp_done), .rsp_error(rsp_error), .soft_reset(soft_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .error(error_w[1]), .err_code(err_code_v[3:2]), .attempt(attempt_v[3:2]));

    // uart_tx stand-in plus pulse monitors, both on the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tx_load_w[k]) begin
                if (!td[k]) badload[k] <= badload[k] + 1;
                if (nbytes[k] < 128) bytes_q[k][nbytes[k]] <= tx_data_v[8*k +: 8];
                nbytes[k] <= nbytes[k] + 1;
            end
            if (tx_start_w[k] && !td[k]) startlow[k] <= startlow[k] + 1;
            if (done_w[k])  ndone[k] <= ndone[k] + 1;
            if (error_w[k]) nerr[k]  <= nerr[k] + 1;
            if (soft_w[k])  nsoft[k] <= nsoft[k] + 1;
            if (tx_start_w[k] && td[k]) begin
                td[k]   <= 1'b0;
                bcnt[k] <= BYTE_CYC;
            end else if (!td[k]) begin
                if (bcnt[k] == 0) td[k] <= 1'b1;
                else              bcnt[k] <= bcnt[k] - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_bytes(input int d, input int target, input string nm);
        int cyc = 0;
        while (nbytes[d] < target && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk(nm, cyc < LIMIT, 1);
    endtask

    task automatic wait_idle(input int d, input string nm);
        int cyc = 0;
        while (busy_w[d] && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk(nm, cyc < LIMIT, 1);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int d = v.d;
        int nb0 = nbytes[v.d], dn0 = ndone[v.d], er0 = nerr[v.d], sr0 = nsoft[v.d];
        int bl0 = badload[v.d], sl0 = startlow[v.d];
        logic [7:0] xb [3];
        xb[0] = v.b0; xb[1] = v.b1; xb[2] = v.b2;
        @(negedge clk);
        pkt_data = v.pkt; expect_rsp = v.er; pv[d] = 1'b1;
        @(negedge clk);
        pv[d] = 1'b0;
        chk($sformatf("v%0d_busy_on_accept", n), busy_w[d], 1);
        chk($sformatf("v%0d_ready_on_accept", n), pkt_ready_w[d], 0);
        wait_bytes(d, nb0 + 3, $sformatf("v%0d_bytes_wait", n));
        if (v.mode != 0) begin
            repeat (60) @(negedge clk);
            rsp_done  = (v.mode == 1 || v.mode == 2);
            rsp_error = (v.mode == 2 || v.mode == 3);
            @(negedge clk);
            rsp_done = 1'b0; rsp_error = 1'b0;
        end
        wait_idle(d, $sformatf("v%0d_idle_wait", n));
        for (int i = 0; i < 3; i++)
            chk($sformatf("v%0d_byte%0d", n, i), bytes_q[d][nb0+i], xb[i]);
        chk($sformatf("v%0d_nbytes", n), nbytes[d] - nb0, 3);
        chk($sformatf("v%0d_done", n), ndone[d] - dn0, v.xdone);
        chk($sformatf("v%0d_error", n), nerr[d] - er0, v.xerr);
        chk($sformatf("v%0d_soft_reset", n), nsoft[d] - sr0, 1);
        chk($sformatf("v%0d_err_code", n), err_code_v[2*d +: 2], v.xcode);
        chk($sformatf("v%0d_attempt", n), attempt_v[2*d +: 2], 1);
        chk($sformatf("v%0d_ready_after", n), pkt_ready_w[d], 1);
        chk($sformatf("v%0d_load_while_busy", n), badload[d] - bl0, 0);
        chk($sformatf("v%0d_start_held", n), (startlow[d] - sl0) >= 3, 1);
    endtask

    initial begin
        int nb0, dn0, er0, sr0, cyc;
        tbl[0] = '{0, 24'hA1B2C3, 1'b0, 0, 8'hC3, 8'hB2, 8'hA1, 1, 0, 2'd0};
        tbl[1] = '{1, 24'hA1B2C3, 1'b0, 0, 8'hA1, 8'hB2, 8'hC3, 1, 0, 2'd0};
        tbl[2] = '{0, 24'hDEADBE, 1'b1, 1, 8'hBE, 8'hAD, 8'hDE, 1, 0, 2'd0};
        tbl[3] = '{0, 24'h123456, 1'b1, 2, 8'h56, 8'h34, 8'h12, 0, 1, 2'd1};
        tbl[4] = '{1, 24'h0F00FF, 1'b1, 3, 8'h0F, 8'h00, 8'hFF, 0, 1, 2'd1};
        tbl[5] = '{0, 24'h00FF80, 1'b0, 0, 8'h80, 8'hFF, 8'h00, 1, 0, 2'd0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_ready", k), pkt_ready_w[k], 1);
            chk($sformatf("rst%0d_busy", k), busy_w[k], 0);
            chk($sformatf("rst%0d_txctl", k), {tx_load_w[k], tx_start_w[k], soft_w[k], done_w[k], error_w[k]}, 0);
            chk($sformatf("rst%0d_code_att", k), {err_code_v[2*k +: 2], attempt_v[2*k +: 2]}, 0);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int n = 0; n < 6; n++) run_vec(tbl[n], n);

        // no response: resend on timeout when compiled in, otherwise wait indefinitely
        nb0 = nbytes[0]; dn0 = ndone[0]; er0 = nerr[0]; sr0 = nsoft[0];
        @(negedge clk);
        pkt_data = 24'hA1B2C3; expect_rsp = 1'b1; pv[0] = 1'b1;
        @(negedge clk);
        pv[0] = 1'b0;
`ifdef UART_PKT_FWD_TIMEOUT_EN
        wait_bytes(0, nb0 + 9, "to_bytes_wait");
        wait_idle(0, "to_idle_wait");
        for (int i = 0; i < 9; i++)
            chk($sformatf("to_byte%0d", i), bytes_q[0][nb0+i], (i % 3 == 0) ? 8'hC3 : (i % 3 == 1) ? 8'hB2 : 8'hA1);
        chk("to_nbytes", nbytes[0] - nb0, 9);
        chk("to_error", nerr[0] - er0, 1);
        chk("to_done", ndone[0] - dn0, 0);
        chk("to_soft_reset", nsoft[0] - sr0, 3);
        chk("to_err_code", err_code_v[1:0], 2);
        chk("to_attempt", attempt_v[1:0], 3);
`else
        wait_bytes(0, nb0 + 3, "nt_bytes_wait");
        repeat (300) @(negedge clk);
        chk("nt_still_busy", busy_w[0], 1);
        chk("nt_nbytes", nbytes[0] - nb0, 3);
        chk("nt_no_error", nerr[0] - er0, 0);
        chk("nt_attempt", attempt_v[1:0], 1);
        rsp_done = 1'b1;
        @(negedge clk);
        rsp_done = 1'b0;
        wait_idle(0, "nt_idle_wait");
        chk("nt_done", ndone[0] - dn0, 1);
        chk("nt_err_code", err_code_v[1:0], 0);
`endif

        // reset during byte 1, with pkt_valid held high throughout
        nb0 = nbytes[0]; dn0 = ndone[0]; er0 = nerr[0];
        @(negedge clk);
        pkt_data = 24'h112233; expect_rsp = 1'b0; pv[0] = 1'b1;
        wait_bytes(0, nb0 + 1, "mr_first_byte_wait");
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("mr_tx_start", tx_start_w[0], 0);
        chk("mr_tx_load", tx_load_w[0], 0);
        chk("mr_busy", busy_w[0], 0);
        chk("mr_ready", pkt_ready_w[0], 1);
        chk("mr_tx_data", tx_data_v[7:0], 0);
        chk("mr_code_att", {err_code_v[1:0], attempt_v[1:0]}, 0);
        repeat (3) @(negedge clk);
        chk("mr_no_pulse", (ndone[0] - dn0) + (nerr[0] - er0), 0);
        chk("mr_no_more_bytes", nbytes[0] - nb0, 1);
        nb0 = nbytes[0]; dn0 = ndone[0];
        reset_n = 1'b1;
        pkt_data = 24'h445566;
        cyc = 0;
        while (!done_w[0] && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("mr_done_wait", cyc < LIMIT, 1);
        pv[0] = 1'b0;
        wait_idle(0, "mr_idle_wait");
        repeat (20) @(negedge clk);
        chk("mr_byte0", bytes_q[0][nb0], 8'h66);
        chk("mr_byte1", bytes_q[0][nb0+1], 8'h55);
        chk("mr_byte2", bytes_q[0][nb0+2], 8'h44);
        chk("mr_single_capture", nbytes[0] - nb0, 3);
        chk("mr_done", ndone[0] - dn0, 1);
        chk("mr_idle_after", busy_w[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end
endmodule
